// File: rtl/mips_defs.sv
// Shared definitions for the interrupt arbiter and the multi-cycle control unit:
// arbiter FSM encodings, default handler vectors and the registered output bundle.
package mips_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_e;

  localparam logic [31:0] DEF_MI_BASE    = 32'h0000_0000;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0004;
  localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0014;

  // Everything the arbiter presents to the control unit, registered as one bundle.
  typedef struct packed {
    logic        interrupt;
    logic        nmint;
    logic        busy;
    logic        in_service;
    logic [2:0]  irq_id;
    logic [31:0] vector_addr;
  } arb_out_t;

  // Handler address of a maskable source; wraps modulo 2^32.
  function automatic logic [31:0] mi_vector(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [2:0]  id);
    return base + ({29'd0, id} * stride);
  endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Arbiter <-> control unit handshake: request/vector out, ack/done back.
interface interrupt_arbiter_if;
  logic        int_ack;
  logic        ack_is_mi;
  logic        int_done;
  logic        interrupt;
  logic        nmint;
  logic        busy;
  logic [2:0]  irq_id;
  logic [31:0] vector_addr;
  logic        in_service;

  modport master (
    input  int_ack, ack_is_mi, int_done,
    output interrupt, nmint, busy, irq_id, vector_addr, in_service
  );

  modport slave (
    output int_ack, ack_is_mi, int_done,
    input  interrupt, nmint, busy, irq_id, vector_addr, in_service
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first eligible bit at or above rr_ptr, wrapping to 0.
module rr_priority_picker #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [2:0]         rr_ptr,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [3:0]         idx;
  logic [NUM_SRC-1:0] sh;

  // Scan offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    idx    = 4'd0;
    sh     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
      sh = eligible >> idx;
      if (sh[0]) begin
        winner = idx[2:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge capture, masking, round-robin selection and the
// request / acknowledge / in-service handshake towards the control unit.
module interrupt_arbiter
  import mips_defs::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] MI_BASE    = DEF_MI_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [31:0] NMI_VECTOR = DEF_NMI_VECTOR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  irq_req,
  input  logic                nmi_req,
  input  logic                mask_we,
  input  logic [NUM_SRC-1:0]  mask_wdata,
  interrupt_arbiter_if.master cu
);

  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  arb_state_e         state_q, state_d;
  arb_out_t           out_q, out_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] clr_mi, mask_sh;
  logic               clr_nmi;
  logic [3:0]         rr_nxt;
  logic [2:0]         win;
  logic               win_vld;

  rr_priority_picker #(.NUM_SRC(NUM_SRC)) u_pick (
    .eligible (pending_q & mask_q),
    .rr_ptr   (rr_ptr_q),
    .winner   (win),
    .valid    (win_vld)
  );

  // Next state: FSM transitions, output bundle, pending bookkeeping.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    rr_ptr_d   = rr_ptr_q;
    prev_d     = irq_req;
    nmi_prev_d = nmi_req;
    mask_d     = mask_we ? mask_wdata : mask_q;
    clr_mi     = '0;
    clr_nmi    = 1'b0;
    mask_sh    = mask_q >> out_q.irq_id;
    rr_nxt     = {1'b0, out_q.irq_id} + 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (nmi_pend_q) begin
          state_d           = ST_REQ;
          out_d.nmint       = 1'b1;
          out_d.vector_addr = NMI_VECTOR;
        end else if (win_vld) begin
          state_d           = ST_REQ;
          out_d.interrupt   = 1'b1;
          out_d.irq_id      = win;
          out_d.vector_addr = mi_vector(MI_BASE, VEC_STRIDE, win);
        end
      end
      ST_REQ: begin
        if (cu.int_ack) begin
          if (cu.ack_is_mi) begin
            clr_mi   = ONE << out_q.irq_id;
            rr_ptr_d = (rr_nxt >= 4'(NUM_SRC)) ? 3'd0 : rr_nxt[2:0];
          end else begin
            clr_nmi = 1'b1;
          end
          state_d          = ST_SERVICE;
          out_d.interrupt  = 1'b0;
          out_d.nmint      = 1'b0;
          out_d.busy       = 1'b1;
          out_d.in_service = 1'b1;
        end else if (out_q.interrupt && nmi_pend_q) begin
          // NMI pre-empts an un-acked maskable request; that source stays pending.
          out_d.interrupt   = 1'b0;
          out_d.nmint       = 1'b1;
          out_d.vector_addr = NMI_VECTOR;
        end else if (out_q.interrupt && !mask_sh[0]) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      end
      ST_SERVICE: begin
        if (cu.int_done) begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    endcase
    // A fresh edge in the clearing cycle wins, so the request is not lost.
    pending_d  = (pending_q & ~clr_mi) | (irq_req & ~prev_q);
    nmi_pend_d = (nmi_pend_q & ~clr_nmi) | (nmi_req & ~nmi_prev_q);
  end

  // State registers; history resets high so lines already asserted need a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      prev_q     <= '1;
      nmi_prev_q <= 1'b1;
      pending_q  <= '0;
      nmi_pend_q <= 1'b0;
      mask_q     <= '0;
      rr_ptr_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      prev_q     <= prev_d;
      nmi_prev_q <= nmi_prev_d;
      pending_q  <= pending_d;
      nmi_pend_q <= nmi_pend_d;
      mask_q     <= mask_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign cu.interrupt   = out_q.interrupt;
  assign cu.nmint       = out_q.nmint;
  assign cu.busy        = out_q.busy;
  assign cu.in_service  = out_q.in_service;
  assign cu.irq_id      = out_q.irq_id;
  assign cu.vector_addr = out_q.vector_addr;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter (NUM_SRC=4, default vectors).
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_req;
  logic       nmi_req;
  logic       mask_we;
  logic [3:0] mask_wdata;
  int         checks = 0;
  int         failures = 0;
  bit         ok;

  interrupt_arbiter_if cu_if ();

  interrupt_arbiter #(.NUM_SRC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_req    (irq_req),
    .nmi_req    (nmi_req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .cu         (cu_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nmi_req = 1'b0; mask_we = 1'b0; mask_wdata = 4'h0;
    cu_if.int_ack = 1'b0; cu_if.ack_is_mi = 1'b0; cu_if.int_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq_req = v; tick(); irq_req = 4'h0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cu_if.interrupt || cu_if.nmint) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack(input logic is_mi);
    cu_if.int_ack = 1'b1; cu_if.ack_is_mi = is_mi;
    tick();
    cu_if.int_ack = 1'b0;
  endtask

  task automatic done();
    cu_if.int_done = 1'b1; tick(); cu_if.int_done = 1'b0;
  endtask

  task automatic serve_mi(input logic [2:0] exp_id);
    wait_req(ok);
    checks++;
    if (!ok || cu_if.interrupt !== 1'b1 || cu_if.irq_id !== exp_id ||
        cu_if.vector_addr !== {27'd0, exp_id, 2'b00}) begin
      failures++;
      $display("FAIL serve_order: got ok=%0b int=%0b id=%0d vec=%h, want id=%0d vec=%h",
               ok, cu_if.interrupt, cu_if.irq_id, cu_if.vector_addr, exp_id, {27'd0, exp_id, 2'b00});
    end
    ack(1'b1);
    done();
  endtask

  task automatic test_reset();
    irq_req = 4'h0;
    do_reset();
    checks++;
    if ({cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service} !== 4'b0 ||
        cu_if.irq_id !== 3'd0 || cu_if.vector_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: int/nmi/busy/insvc=%b id=%0d vec=%h, want all 0",
               {cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service}, cu_if.irq_id, cu_if.vector_addr);
    end
    ack(1'b1);
    checks++;
    if (cu_if.busy !== 1'b0 || cu_if.in_service !== 1'b0) begin
      failures++;
      $display("FAIL ack_in_idle: busy=%b insvc=%b, want 0 0", cu_if.busy, cu_if.in_service);
    end
  endtask

  task automatic test_basic();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'hF);
    irq_req = 4'b0100;
    tick();
    checks++;
    if (cu_if.interrupt !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: interrupt=%b one cycle after edge, want 0", cu_if.interrupt);
    end
    irq_req = 4'h0;
    tick();
    checks++;
    if (cu_if.interrupt !== 1'b1 || cu_if.irq_id !== 3'd2 || cu_if.vector_addr !== 32'h8) begin
      failures++;
      $display("FAIL basic_request: int=%b id=%0d vec=%h, want 1 2 00000008",
               cu_if.interrupt, cu_if.irq_id, cu_if.vector_addr);
    end
    ack(1'b1);
    checks++;
    if (cu_if.busy !== 1'b1 || cu_if.in_service !== 1'b1 || cu_if.interrupt !== 1'b0 ||
        cu_if.irq_id !== 3'd2 || cu_if.vector_addr !== 32'h8) begin
      failures++;
      $display("FAIL basic_service: busy=%b insvc=%b int=%b id=%0d vec=%h, want 1 1 0 2 00000008",
               cu_if.busy, cu_if.in_service, cu_if.interrupt, cu_if.irq_id, cu_if.vector_addr);
    end
    done();
    checks++;
    if ({cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service} !== 4'b0 ||
        cu_if.irq_id !== 3'd0 || cu_if.vector_addr !== 32'h0) begin
      failures++;
      $display("FAIL basic_done: int/nmi/busy/insvc=%b id=%0d vec=%h, want all 0",
               {cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service}, cu_if.irq_id, cu_if.vector_addr);
    end
  endtask

  task automatic test_round_robin();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'hF);
    pulse_irq(4'b1011);
    serve_mi(3'd0);
    serve_mi(3'd1);
    serve_mi(3'd3);
    tick(); tick();
    checks++;
    if (cu_if.interrupt !== 1'b0) begin
      failures++;
      $display("FAIL rr_drained: interrupt=%b, want 0", cu_if.interrupt);
    end
    pulse_irq(4'b1001);
    serve_mi(3'd0);
    serve_mi(3'd3);
  endtask

  task automatic test_nmi_preempt();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'hF);
    pulse_irq(4'b0010);
    wait_req(ok);
    checks++;
    if (!ok || cu_if.interrupt !== 1'b1 || cu_if.irq_id !== 3'd1) begin
      failures++;
      $display("FAIL nmi_setup: ok=%b int=%b id=%0d, want 1 1 1", ok, cu_if.interrupt, cu_if.irq_id);
    end
    nmi_req = 1'b1;
    tick(); tick();
    nmi_req = 1'b0;
    checks++;
    if (cu_if.interrupt !== 1'b0 || cu_if.nmint !== 1'b1 || cu_if.vector_addr !== 32'h14) begin
      failures++;
      $display("FAIL nmi_preempt: int=%b nmint=%b vec=%h, want 0 1 00000014",
               cu_if.interrupt, cu_if.nmint, cu_if.vector_addr);
    end
    ack(1'b0);
    checks++;
    if (cu_if.busy !== 1'b1 || cu_if.nmint !== 1'b0 || cu_if.vector_addr !== 32'h14) begin
      failures++;
      $display("FAIL nmi_service: busy=%b nmint=%b vec=%h, want 1 0 00000014",
               cu_if.busy, cu_if.nmint, cu_if.vector_addr);
    end
    done();
    tick();
    checks++;
    if (cu_if.interrupt !== 1'b1 || cu_if.nmint !== 1'b0 || cu_if.irq_id !== 3'd1 ||
        cu_if.vector_addr !== 32'h4) begin
      failures++;
      $display("FAIL nmi_represent: int=%b nmint=%b id=%0d vec=%h, want 1 0 1 00000004",
               cu_if.interrupt, cu_if.nmint, cu_if.irq_id, cu_if.vector_addr);
    end
  endtask

  task automatic test_mask();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'h0);
    pulse_irq(4'b0001);
    tick(); tick(); tick();
    checks++;
    if (cu_if.interrupt !== 1'b0 || cu_if.nmint !== 1'b0) begin
      failures++;
      $display("FAIL masked_hold: int=%b nmint=%b, want 0 0", cu_if.interrupt, cu_if.nmint);
    end
    set_mask(4'b0001);
    ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (cu_if.interrupt) ok = 1'b1;
    end
    checks++;
    if (!ok || cu_if.irq_id !== 3'd0) begin
      failures++;
      $display("FAIL unmask_request: seen=%b id=%0d, want 1 0", ok, cu_if.irq_id);
    end
    set_mask(4'h0);
    tick();
    checks++;
    if (cu_if.interrupt !== 1'b0 || cu_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL mask_drop: int=%b busy=%b, want 0 0", cu_if.interrupt, cu_if.busy);
    end
  endtask

  task automatic test_level_at_reset();
    irq_req = 4'b0010;
    do_reset();
    set_mask(4'hF);
    tick(); tick(); tick();
    checks++;
    if (cu_if.interrupt !== 1'b0) begin
      failures++;
      $display("FAIL held_through_reset: interrupt=%b, want 0", cu_if.interrupt);
    end
    irq_req = 4'h0; tick();
    irq_req = 4'b0010; tick();
    irq_req = 4'h0;
    wait_req(ok);
    checks++;
    if (!ok || cu_if.irq_id !== 3'd1) begin
      failures++;
      $display("FAIL new_edge_after_reset: seen=%b id=%0d, want 1 1", ok, cu_if.irq_id);
    end
  endtask

  task automatic test_reset_in_service();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'hF);
    pulse_irq(4'b0001);
    wait_req(ok);
    ack(1'b1);
    pulse_irq(4'b1000);
    tick();
    checks++;
    if (cu_if.busy !== 1'b1 || cu_if.interrupt !== 1'b0) begin
      failures++;
      $display("FAIL no_nesting: busy=%b int=%b, want 1 0", cu_if.busy, cu_if.interrupt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_service: int/nmi/busy/insvc=%b, want 0000",
               {cu_if.interrupt, cu_if.nmint, cu_if.busy, cu_if.in_service});
    end
    set_mask(4'hF);
    tick(); tick(); tick();
    done();
    checks++;
    if (cu_if.interrupt !== 1'b0 || cu_if.busy !== 1'b0 || cu_if.in_service !== 1'b0) begin
      failures++;
      $display("FAIL pending_lost: int=%b busy=%b insvc=%b, want 0 0 0",
               cu_if.interrupt, cu_if.busy, cu_if.in_service);
    end
  endtask

  task automatic test_back_to_back();
    irq_req = 4'h0;
    do_reset();
    set_mask(4'hF);
    pulse_irq(4'b0001);
    wait_req(ok);
    cu_if.int_ack = 1'b1; cu_if.ack_is_mi = 1'b1; cu_if.int_done = 1'b1;
    irq_req = 4'b0001;
    tick();
    cu_if.int_ack = 1'b0; cu_if.int_done = 1'b0; irq_req = 4'h0;
    tick();
    checks++;
    if (cu_if.busy !== 1'b1 || cu_if.in_service !== 1'b1) begin
      failures++;
      $display("FAIL ack_with_done: busy=%b insvc=%b, want 1 1", cu_if.busy, cu_if.in_service);
    end
    done();
    wait_req(ok);
    checks++;
    if (!ok || cu_if.interrupt !== 1'b1 || cu_if.irq_id !== 3'd0) begin
      failures++;
      $display("FAIL set_wins_clear: seen=%b int=%b id=%0d, want 1 1 0", ok, cu_if.interrupt, cu_if.irq_id);
    end
  endtask

  initial begin
    irq_req = 4'h0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_nmi_preempt();
    test_mask();
    test_level_at_reset();
    test_reset_in_service();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
